hazard_stall_unit: RTL and testbench

//  Stall/flush counterpart to the EX-stage operand-forwarding logic: handles the hazards bypassing

---
 rtl/hazard_stall_unit_pkg.sv | 17 +
 rtl/hazard_stall_unit_if.sv | 35 +++
 rtl/hazard_stall_unit_sat_counter.sv | 19 +
 rtl/hazard_stall_unit.sv | 117 +++++++++++
 tb/tb_hazard_stall_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and defaults for the pipeline hazard stall/flush unit.
package hazard_stall_unit_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_t;

  localparam int REG_AW_DEF  = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 16;
  localparam int CNT_W_DEF   = 32;

  // Architectural register $zero; never a real data dependency.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side hazard inputs and stall/flush controls of the hazard stall unit.
interface hazard_stall_unit_if #(
  parameter int REG_AW = hazard_stall_unit_pkg::REG_AW_DEF,
  parameter int CNT_W  = hazard_stall_unit_pkg::CNT_W_DEF
);
  logic              IDEX_MemRead_i;
  logic [REG_AW-1:0] IDEX_Rt_i;
  logic [REG_AW-1:0] IFID_Rs_i;
  logic [REG_AW-1:0] IFID_Rt_i;
  logic              IFID_useRt_i;
  logic              EX_branch_taken_i;
  logic              EX_mdu_start_i;
  logic              EX_mdu_is_div_i;
  logic              PC_write_o;
  logic              IFID_write_o;
  logic              IFID_flush_o;
  logic              IDEX_write_o;
  logic              IDEX_bubble_o;
  logic              EXMEM_bubble_o;
  logic [CNT_W-1:0]  stall_cycles_o;

  modport master (
    output IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, IFID_useRt_i,
           EX_branch_taken_i, EX_mdu_start_i, EX_mdu_is_div_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
           IDEX_bubble_o, EXMEM_bubble_o, stall_cycles_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, IFID_useRt_i,
           EX_branch_taken_i, EX_mdu_start_i, EX_mdu_is_div_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
           IDEX_bubble_o, EXMEM_bubble_o, stall_cycles_o
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and increment enable.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubble, MUL/DIV front-end freeze and taken-branch squash controller.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_stall_unit_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // Busy state covers cycles 2..L of the operation, so it is loaded with L-2.
  localparam logic [CW-1:0] MUL_INIT  = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DIV_INIT  = CW'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam bit            MUL_MULTI = (MUL_LAT > 1);
  localparam bit            DIV_MULTI = (DIV_LAT > 1);

  hz_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mdu_multi;
  logic [CW-1:0]   mdu_init;
  logic            load_use;
  logic            pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble;
  logic [CNT_W-1:0] stall_cycles;

  assign mdu_multi = bus.EX_mdu_is_div_i ? DIV_MULTI : MUL_MULTI;
  assign mdu_init  = bus.EX_mdu_is_div_i ? DIV_INIT  : MUL_INIT;

  assign load_use = bus.IDEX_MemRead_i
                  && (bus.IDEX_Rt_i != REG_AW'(ZERO_REG))
                  && ((bus.IDEX_Rt_i == bus.IFID_Rs_i)
                      || (bus.IFID_useRt_i && (bus.IDEX_Rt_i == bus.IFID_Rt_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (!bus.EX_branch_taken_i && bus.EX_mdu_start_i && mdu_multi) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = mdu_init;
        end
      end
      MDU_BUSY: begin
        if (cnt == '0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (rst_i) begin
      // Reset cycle keeps the default pass-through controls.
    end else if (state == MDU_BUSY) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (bus.EX_branch_taken_i) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.EX_mdu_start_i) begin
      if (mdu_multi) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  assign bus.PC_write_o     = pc_write;
  assign bus.IFID_write_o   = ifid_write;
  assign bus.IFID_flush_o   = ifid_flush;
  assign bus.IDEX_write_o   = idex_write;
  assign bus.IDEX_bubble_o  = idex_bubble;
  assign bus.EXMEM_bubble_o = exmem_bubble;
  assign bus.stall_cycles_o = stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized checks of hazard_stall_unit against a cycle-level behavioural model.
module tb_hazard_stall_unit;

  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Output vector order: {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_bubble}
  localparam logic [5:0] O_DEFAULT = 6'b110100;
  localparam logic [5:0] O_FREEZE  = 6'b000001;
  localparam logic [5:0] O_BRANCH  = 6'b111110;
  localparam logic [5:0] O_LOADUSE = 6'b000110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(
    .REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int freeze_left = 0;   // front-end freeze cycles still owed after the current one
  int model_cnt   = 0;
  logic [5:0] exp_out;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic drive(input bit r, input bit mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input bit use_rt, input bit br, input bit st,
                       input bit dv);
    rst                   = r;
    bus.IDEX_MemRead_i    = mr;
    bus.IDEX_Rt_i         = ex_rt;
    bus.IFID_Rs_i         = rs;
    bus.IFID_Rt_i         = rt;
    bus.IFID_useRt_i      = use_rt;
    bus.EX_branch_taken_i = br;
    bus.EX_mdu_start_i    = st;
    bus.EX_mdu_is_div_i   = dv;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [5:0] dut_out();
    return {bus.PC_write_o, bus.IFID_write_o, bus.IFID_flush_o,
            bus.IDEX_write_o, bus.IDEX_bubble_o, bus.EXMEM_bubble_o};
  endfunction

  // Expected outputs from the hazard rules, then the model advances across the clock edge.
  task automatic cycle();
    int lat;
    int next_freeze;
    bit hz;
    #1;
    hz = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != 0) &&
         (bus.IDEX_Rt_i == bus.IFID_Rs_i ||
          (bus.IFID_useRt_i && bus.IDEX_Rt_i == bus.IFID_Rt_i));
    lat = bus.EX_mdu_is_div_i ? DIV_LAT : MUL_LAT;
    next_freeze = 0;
    if (rst)                          exp_out = O_DEFAULT;
    else if (freeze_left > 0) begin   exp_out = O_FREEZE; next_freeze = freeze_left - 1; end
    else if (bus.EX_branch_taken_i)   exp_out = O_BRANCH;
    else if (bus.EX_mdu_start_i) begin
      exp_out = (lat > 1) ? O_FREEZE : O_DEFAULT;
      next_freeze = lat - 1;
    end
    else if (hz)                      exp_out = O_LOADUSE;
    else                              exp_out = O_DEFAULT;
    check("ctrl_outputs", 32'(dut_out()), 32'(exp_out));
    check("stall_cycles", 32'(bus.stall_cycles_o), 32'(model_cnt));
    @(posedge clk);
    if (rst) begin
      freeze_left = 0;
      model_cnt   = 0;
    end else begin
      freeze_left = next_freeze;
      if (!exp_out[5] && model_cnt < CNT_MAX) model_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  initial begin
    int n_stall;
    int n_plain;
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: basic load-use, one bubble
    idle_in(); #1;
    check("t1_reset_cnt", 32'(bus.stall_cycles_o), 32'd0);
    drive(0, 1, 8, 8, 0, 0, 0, 0, 0); #1;
    check("t1_lu_outputs", 32'(dut_out()), 32'(O_LOADUSE));
    cycle();
    idle_in(); #1;
    check("t1_cnt_after", 32'(bus.stall_cycles_o), 32'd1);
    cycle();

    // 2: $zero never stalls; rt only matters with useRt
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0); #1;
    check("t2_zero_reg", 32'(bus.PC_write_o), 32'd1);
    cycle();
    drive(0, 1, 9, 3, 9, 0, 0, 0, 0); #1;
    check("t2_rt_unused", 32'(bus.PC_write_o), 32'd1);
    cycle();
    drive(0, 1, 9, 3, 9, 1, 0, 0, 0); #1;
    check("t2_rt_used", 32'(bus.PC_write_o), 32'd0);
    cycle();

    // 3: multiply freezes four cycles, IDLE on the fifth
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (dut_out() == O_FREEZE) n_stall++;
      cycle();
      idle_in();
    end
    check("t3_mul_freeze_cycles", 32'(n_stall), 32'd4);
    #1;
    check("t3_fifth_default", 32'(dut_out()), 32'(O_DEFAULT));
    check("t3_cnt", 32'(bus.stall_cycles_o), 32'd4);
    cycle();

    // 4: divide with a load-use held the whole time
    do_reset();
    drive(0, 1, 7, 7, 0, 0, 0, 1, 1);
    n_stall = 0;
    n_plain = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!bus.PC_write_o) n_stall++;
      if (!bus.IDEX_bubble_o) n_plain++;
      cycle();
      drive(0, 1, 7, 7, 0, 0, 0, 0, 0);
    end
    check("t4_div_stalls", 32'(n_stall), 32'd16);
    check("t4_no_bubble", 32'(n_plain), 32'd16);
    #1;
    check("t4_17th_loaduse", 32'(dut_out()), 32'(O_LOADUSE));
    cycle();
    idle_in(); #1;
    check("t4_18th_default", 32'(dut_out()), 32'(O_DEFAULT));
    cycle();

    // 5: branch outranks mdu_start and load-use
    drive(0, 1, 4, 4, 0, 0, 1, 1, 1); #1;
    check("t5_branch", 32'(dut_out()), 32'(O_BRANCH));
    cycle();
    idle_in(); #1;
    check("t5_no_busy", 32'(bus.PC_write_o), 32'd1);
    cycle();

    // 6: reset mid-divide abandons it
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    idle_in();
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t6_reset_cycle", 32'(dut_out()), 32'(O_DEFAULT));
    cycle();
    idle_in(); #1;
    check("t6_after_reset", 32'(dut_out()), 32'(O_DEFAULT));
    check("t6_cnt_cleared", 32'(bus.stall_cycles_o), 32'd0);
    cycle();

    // 6b: two back-to-back divides saturate the 4-bit counter
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 16; i++) begin
        cycle();
        idle_in();
      end
    end
    #1;
    check("t6_saturated", 32'(bus.stall_cycles_o), 32'd15);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 59) == 0),
            $urandom_range(0, 1),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0),
            $urandom_range(0, 1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
